cic_dc_block_fifo: RTL and testbench

Downstream stage of the CIC decimator in the AM demodulator chain. It detects each rising edge of the CIC sample clock `d_clk` in the system `clk` domain and captures the CIC's 8-bit signed output. It removes the carrier-envelope DC offset with a first-order leaky-integrator high-pass and buffers the audio samples in a small FIFO. The FIFO drains through a valid/ready handshake toward the audio output stage (PWM/DAC).

---
 rtl/cic_dc_block_fifo.sv | 109 ++++++++++
 tb/tb_cic_dc_block_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_dc_block_fifo.sv
// CIC output capture, leaky-integrator DC removal and show-ahead sample FIFO.
// Latency: d_clk rise sampled -> m_valid 2 clk edges; push is dropped (sticky overflow) only when full with no pop.
module cic_dc_block_fifo #(
  parameter int DW    = 8,
  parameter int K     = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] d_in,
  input  logic                 d_clk,
  output logic signed [DW-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AW:0]          count,
  output logic                 overflow
);

  localparam int AccW = DW + K + 2;
  localparam int EW   = DW + 2;

  logic                   d_clk_q;
  logic                   stb;
  logic                   stb_q;
  logic signed [DW-1:0]   x_q;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [EW-1:0]   dc, e;
  logic signed [DW-1:0]   y;

  logic [DW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q, count_d;
  logic                   overflow_q;
  logic                   full, push, pop, drop;

  assign stb = d_clk & ~d_clk_q;

  // dc fits in EW bits because |acc| stays below 2^(DW+K+1) for legal inputs
  assign dc    = EW'(acc_q >>> K);
  assign e     = {{2{x_q[DW-1]}}, x_q} - dc;
  assign acc_d = acc_q + {{(AccW-EW){e[EW-1]}}, e};

  always_comb begin
    y = e[DW-1:0];
    if (e[EW-1:DW-1] != {3{e[EW-1]}}) begin
      y = e[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign full = (count_q == (AW+1)'(DEPTH));
  assign pop  = m_valid & m_ready;
  assign push = stb_q & (~full | pop);
  assign drop = stb_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_clk_q    <= 1'b0;
      stb_q      <= 1'b0;
      x_q        <= '0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      d_clk_q <= d_clk;
      stb_q   <= stb;
      if (stb) begin
        x_q <= d_in;
      end
      // the filter advances even when the sample is dropped
      if (stb_q) begin
        acc_q <= acc_d;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y;
    end
  end

  assign m_valid  = (count_q != '0);
  assign m_data   = m_valid ? $signed(mem_q[rd_ptr_q]) : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cic_dc_block_fifo.sv
// Randomized bench for cic_dc_block_fifo against an arithmetic filter + queue reference model.
module tb_cic_dc_block_fifo;

  localparam int K = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] d_in = '0;
  logic              d_clk = 1'b0;
  logic signed [7:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [4:0]        count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  int m_acc = 0;
  int exp_q[$];
  int dut_q[$];
  bit m_ovf = 0;
  bit pend_vld = 0;
  int pend_x = 0;
  bit prev_dclk = 0;

  cic_dc_block_fifo #(.DW(8), .K(K), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_clk(d_clk),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  // High-pass reference: dc = floor(acc / 2^K), e = x - dc, output clamped e, acc += e.
  function automatic int filt(int x);
    int dc, e;
    dc = (m_acc >= 0) ? m_acc / (2**K) : -((-m_acc + (2**K) - 1) / (2**K));
    e = x - dc;
    m_acc += e;
    if (e > 127) return 127;
    if (e < -128) return -128;
    return e;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_acc = 0; m_ovf = 0; pend_vld = 0; pend_x = 0; prev_dclk = 0;
  endtask

  // Drives one cycle from a negedge and advances the reference to the following edge.
  task automatic advance(input logic dclk, input int din, input logic rdy);
    bit pop;
    d_clk = dclk; d_in = din[7:0]; m_ready = rdy;
    if (rdy && m_valid) dut_q.push_back(int'(m_data));
    pop = rdy && (exp_q.size() != 0);
    if (pop) void'(exp_q.pop_front());
    if (pend_vld) begin
      int y;
      y = filt(pend_x);
      if (exp_q.size() < 16) exp_q.push_back(y);
      else m_ovf = 1;
    end
    pend_vld = dclk && !prev_dclk;
    pend_x = din;
    prev_dclk = dclk;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; d_clk = 1'b0; m_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      d_clk = 1'($urandom_range(0, 1)); d_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || m_data !== 8'sd0) begin
        errors++;
        $display("FAIL reset_hold: got valid=%b count=%0d ovf=%b data=%0d expected 0 0 0 0", m_valid, count, overflow, m_data);
      end
    end
    d_clk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || count !== 5'd0) begin
        errors++;
        $display("FAIL reset_release: got valid=%b count=%0d expected 0 0", m_valid, count);
      end
    end
  endtask

  task automatic test_step();
    dut_q.delete();
    for (int s = 0; s < 400; s++) begin
      for (int c = 0; c < 8; c++) begin
        advance(c < 4, 64, 1'b1);
        if (s == 0 && c < 2) begin
          checks++;
          if (m_valid !== (c == 1)) begin
            errors++;
            $display("FAIL step_latency: cycle %0d got valid=%b expected %b", c, m_valid, c == 1);
          end
        end
        checks++;
        if (m_valid !== (exp_q.size() != 0) || count !== 5'(exp_q.size())) begin
          errors++;
          $display("FAIL step_state: got valid=%b count=%0d expected count %0d", m_valid, count, exp_q.size());
        end
        if (exp_q.size() != 0) begin
          checks++;
          if (int'(m_data) !== exp_q[0]) begin
            errors++;
            $display("FAIL step_data: got %0d expected %0d", m_data, exp_q[0]);
          end
        end
      end
    end
    checks++;
    if (dut_q.size() != 400 || dut_q[0] != 64 || dut_q[1] != 63) begin
      errors++;
      $display("FAIL step_first: got n=%0d first=%0d,%0d expected 400 64,63", dut_q.size(), dut_q[0], dut_q[1]);
    end
    checks++;
    if (dut_q[dut_q.size()-1] > 1 || dut_q[dut_q.size()-1] < -1) begin
      errors++;
      $display("FAIL step_settle: got %0d expected |y|<=1", dut_q[dut_q.size()-1]);
    end
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 1000; s++) begin
      for (int c = 0; c < 2; c++) begin
        advance(c == 0, 127, 1'b1);
        if (exp_q.size() != 0) begin
          checks++;
          if (int'(m_data) !== exp_q[0]) begin
            errors++;
            $display("FAIL sat_settle_data: got %0d expected %0d", m_data, exp_q[0]);
          end
        end
      end
    end
    advance(1'b0, 127, 1'b1);
    advance(1'b0, 127, 1'b1);
    dut_q.delete();
    for (int s = 0; s < 300; s++) begin
      for (int c = 0; c < 2; c++) begin
        advance(c == 0, -128, 1'b1);
        checks++;
        if (count !== 5'(exp_q.size()) || (exp_q.size() != 0 && int'(m_data) !== exp_q[0])) begin
          errors++;
          $display("FAIL sat_step_data: got count=%0d data=%0d expected count %0d", count, m_data, exp_q.size());
        end
      end
    end
    advance(1'b0, -128, 1'b1);
    checks++;
    if (dut_q.size() != 300 || dut_q[0] != -128) begin
      errors++;
      $display("FAIL sat_clamp: got n=%0d first=%0d expected 300 -128", dut_q.size(), dut_q[0]);
    end
    for (int i = 1; i < dut_q.size(); i++) begin
      checks++;
      if (dut_q[i] < dut_q[i-1] || dut_q[i] > 0) begin
        errors++;
        $display("FAIL sat_monotonic: sample %0d got %0d after %0d expected non-decreasing <=0", i, dut_q[i], dut_q[i-1]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    dut_q.delete();
    for (int s = 1; s <= 17; s++) begin
      for (int c = 0; c < 4; c++) begin
        advance(c < 2, s, 1'b0);
        checks++;
        if (count !== 5'(exp_q.size()) || overflow !== m_ovf) begin
          errors++;
          $display("FAIL ovf_fill: got count=%0d ovf=%b expected %0d %b", count, overflow, exp_q.size(), m_ovf);
        end
      end
    end
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ovf=%b expected 16 1", count, overflow);
    end
    for (int c = 0; c < 20; c++) begin
      advance(1'b0, 0, 1'b1);
      if (exp_q.size() != 0) begin
        checks++;
        if (int'(m_data) !== exp_q[0]) begin
          errors++;
          $display("FAIL ovf_drain_data: got %0d expected %0d", m_data, exp_q[0]);
        end
      end
    end
    checks++;
    if (dut_q.size() != 16 || dut_q[0] != 1 || count !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: got n=%0d first=%0d count=%0d valid=%b ovf=%b expected 16 1 0 0 1",
               dut_q.size(), dut_q[0], count, m_valid, overflow);
    end
  endtask

  task automatic test_edge_and_full_pop();
    int x;
    do_reset();
    dut_q.delete();
    for (int c = 0; c < 55; c++) begin
      advance(c < 50, 37, 1'b1);
    end
    checks++;
    if (dut_q.size() != 1 || dut_q[0] != 37) begin
      errors++;
      $display("FAIL edge_hold: got %0d samples first=%0d expected 1 sample 37", dut_q.size(), dut_q[0]);
    end
    for (int s = 0; s < 16; s++) begin
      x = int'($urandom_range(0, 255)) - 128;
      advance(1'b1, x, 1'b0);
      advance(1'b0, x, 1'b0);
    end
    x = int'($urandom_range(0, 255)) - 128;
    advance(1'b1, x, 1'b0);
    advance(1'b0, x, 1'b1);
    advance(1'b0, x, 1'b0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b expected 16 0", count, overflow);
    end
    for (int c = 0; c < 18; c++) begin
      advance(1'b0, 0, 1'b1);
      if (exp_q.size() != 0) begin
        checks++;
        if (int'(m_data) !== exp_q[0]) begin
          errors++;
          $display("FAIL full_drain_data: got %0d expected %0d", m_data, exp_q[0]);
        end
      end
    end
    checks++;
    if (count !== 5'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_end: got count=%0d valid=%b expected 0 0", count, m_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int x;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      advance(1'b1, 50 + s, 1'b0);
      advance(1'b0, 50 + s, 1'b0);
    end
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL mid_fill: got count=%0d expected 5", count);
    end
    x = int'($urandom_range(0, 255)) - 128;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'sd0) begin
      errors++;
      $display("FAIL mid_async: got count=%0d valid=%b data=%0d expected 0 0 0", count, m_valid, m_data);
    end
    model_clear();
    d_clk = 1'b1; d_in = x[7:0];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dut_q.delete();
    for (int c = 0; c < 8; c++) begin
      advance(c < 4, x, 1'b1);
    end
    checks++;
    if (dut_q.size() != 1 || dut_q[0] != x) begin
      errors++;
      $display("FAIL mid_first: got n=%0d first=%0d expected 1 sample %0d", dut_q.size(), dut_q[0], x);
    end
  endtask

  task automatic test_random();
    int x, hi, lo;
    do_reset();
    for (int s = 0; s < 300; s++) begin
      x = int'($urandom_range(0, 255)) - 128;
      hi = int'($urandom_range(1, 3));
      lo = int'($urandom_range(1, 3));
      for (int c = 0; c < hi + lo; c++) begin
        advance(c < hi, x, 1'($urandom_range(0, 3) != 0 || s > 280));
        checks++;
        if (m_valid !== (exp_q.size() != 0) || count !== 5'(exp_q.size()) || overflow !== m_ovf) begin
          errors++;
          $display("FAIL rand_state: got valid=%b count=%0d ovf=%b expected count %0d ovf %b",
                   m_valid, count, overflow, exp_q.size(), m_ovf);
        end
        if (exp_q.size() != 0) begin
          checks++;
          if (int'(m_data) !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_data: got %0d expected %0d", m_data, exp_q[0]);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_step();
    test_saturation();
    test_overflow();
    test_edge_and_full_pop();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
